// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter
//   Round-robin arbiter that produces the select for a downstream 4:1 mux.
//   One requester is granted at a time. The grant lasts for at most MAX_BURST
//   handshaked beats. After that, priority rotates to the index after the
//   last owner.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   req    : per-requester request (bit i = mux input i has data)
//   ready  : downstream accepts a beat this cycle
//   s      : registered mux select = index of granted requester
//   gnt    : registered one-hot grant, zero while idle
//   valid  : registered, mux output carries a granted beat
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner; arbitrate among req starting at ptr
// ST_GRANT | requester s owns the mux; count beats until release
module rr_select_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       xfer;
  logic       last_beat;
  logic       drop;

  // Rotating priority search. The loop runs from the farthest offset down to
  // offset 0, so the request closest to ptr is the last one to assign pick
  // and therefore wins.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
  end

  assign xfer      = valid & ready & req[s];
  assign last_beat = xfer && (cnt == CNT_LAST);
  // A requester that withdraws gives up the grant without a beat counted.
  assign drop      = ~req[s];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      s     <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            s     <= pick;
            gnt   <= 4'b0001 << pick;
            valid <= 1'b1;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (drop || last_beat) begin
            // s is held so the mux select stays stable while idle.
            state <= ST_IDLE;
            valid <= 1'b0;
            gnt   <= 4'b0000;
            ptr   <= s + 2'd1;
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter
//   Directed scenarios followed by randomized traffic. Outputs are checked
//   every cycle against a transaction-level model: owner index, beats served
//   and next-priority index.
module tb_rr_select_arbiter;

  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       valid;

  rr_select_arbiter #(.MAX_BURST(MB), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .s     (s),
    .gnt   (gnt),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Model: owner < 0 means nobody is granted.
  int m_owner = -1;
  int m_beats = 0;
  int m_next  = 0;
  int m_sel   = 0;

  int beats_seen = 0;
  int grant_log[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r_n, input logic [3:0] rq, input logic rd);
    if (!r_n) begin
      m_owner = -1; m_beats = 0; m_next = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && rq[(m_next + k) % 4]) begin
          m_owner = (m_next + k) % 4;
          m_sel   = m_owner;
          m_beats = 0;
        end
      end
    end else if (!rq[m_owner]) begin
      m_next  = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (rd) begin
      m_beats++;
      if (m_beats == MB) begin
        m_next  = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  // One clock: apply inputs, count a DUT beat if one happens at this edge,
  // advance the model, then compare just after the edge.
  task automatic step(input logic r_n, input logic [3:0] rq, input logic rd);
    rst_n = r_n; req = rq; ready = rd;
    #1;
    if (r_n && valid && rd && rq[s]) beats_seen++;
    @(posedge clk);
    model_edge(r_n, rq, rd);
    #1;
    chk("valid", int'(valid), (m_owner >= 0) ? 1 : 0);
    chk("gnt",   int'(gnt),   (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("s",     int'(s),     m_sel);
    if (valid && !prev_valid) grant_log.push_back(int'(s));
    prev_valid = valid;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; req = 4'b0000; ready = 1'b0;

    // Reset and idle
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);
    chk("rst_s", int'(s), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(valid), 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b0000, 1);
      chk("idle_valid", int'(valid), 0);
      chk("idle_gnt", int'(gnt), 0);
    end

    // Single requester full burst: 4 beats, 1 idle, re-grant
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b0100, 1);
      chk("single_s", int'(s), 2);
      chk("single_gnt", int'(gnt), 4);
      chk("single_valid", int'(valid), 1);
    end
    step(1, 4'b0100, 1);
    chk("single_idle_valid", int'(valid), 0);
    chk("single_idle_s", int'(s), 2);
    step(1, 4'b0100, 1);
    chk("single_regrant_valid", int'(valid), 1);
    chk("single_regrant_s", int'(s), 2);

    // Round-robin rotation with wrap
    step(0, 4'b0000, 0);
    grant_log.delete();
    for (int i = 0; i < 24; i++) step(1, 4'b1111, 1);
    chk("rr_count", (grant_log.size() >= 5) ? 1 : 0, 1);
    if (grant_log.size() >= 5) begin
      chk("rr_g0", grant_log[0], 0);
      chk("rr_g1", grant_log[1], 1);
      chk("rr_g2", grant_log[2], 2);
      chk("rr_g3", grant_log[3], 3);
      chk("rr_g4", grant_log[4], 0);
    end

    // Backpressure: 3 stall cycles mid-burst, 4 beats total
    step(0, 4'b0000, 0);
    beats_seen = 0;
    step(1, 4'b0010, 1);
    step(1, 4'b0010, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0010, 0);
      chk("stall_s", int'(s), 1);
      chk("stall_gnt", int'(gnt), 2);
      chk("stall_valid", int'(valid), 1);
    end
    n = 0;
    while (valid && n < 10) begin
      step(1, 4'b0010, 1);
      n++;
    end
    chk("stall_release_bound", (n < 10) ? 1 : 0, 1);
    chk("stall_beats", beats_seen, 4);

    // Early drop: req[3] falls after 2 beats, pending req[0] next
    step(0, 4'b0000, 0);
    step(1, 4'b1000, 1);
    chk("drop_grant_s", int'(s), 3);
    step(1, 4'b1000, 1);
    step(1, 4'b1000, 1);
    step(1, 4'b0001, 1);
    chk("drop_valid", int'(valid), 0);
    chk("drop_gnt", int'(gnt), 0);
    step(1, 4'b0001, 1);
    chk("drop_next_s", int'(s), 0);
    chk("drop_next_gnt", int'(gnt), 1);

    // Reset mid-burst
    step(0, 4'b0000, 0);
    step(1, 4'b0100, 1);
    step(1, 4'b0100, 1);
    step(0, 4'b0100, 1);
    chk("midrst_s", int'(s), 0);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_valid", int'(valid), 0);
    step(1, 4'b1111, 1);
    chk("midrst_ptr_grant", int'(s), 0);

    // Randomized traffic
    begin
      logic [3:0] rq;
      rq = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
        step(($urandom_range(0, 199) != 0), rq, ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
